// File: rtl/axi_top_32x32_ws.sv
// AXI4 slave front-end for the 32x32 weight-stationary array.
// Exposes a word-addressed local buffer to the host with full burst support.
// The read and write engines are independent and share a single clock domain.
module axi_top_32x32_ws #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 20,
  parameter int STRB_WIDTH      = DATA_WIDTH/8,
  parameter int ID_WIDTH        = 8,
  parameter bit PIPELINE_OUTPUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int DEPTH = 2**(ADDR_WIDTH-LSB);

  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_PREP, R_BURST} rstate_t;

  // Address of the following beat: FIXED holds, WRAP folds into the aligned
  // (len+1)<<size window, INCR and the reserved encoding step by 1<<size.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;
    incr  = ADDR_WIDTH'(1) << size;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (addr & ~wmask) | ((addr + incr) & wmask);
      default: f_next_addr = addr + incr;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_awready, r_wready, r_bvalid;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic [ID_WIDTH-1:0]   r_bid;
  logic                  w_aw_hs, w_w_hs;

  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid;
  logic                  w_arready_nxt, w_rvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr, w_faddr;
  logic [7:0]            r_rlen, r_rbeat, w_flen, w_fbeat;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rlast;
  logic                  w_ar_hs, w_r_hs, w_fetch;
  logic                  w_unused_ok;

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid & r_wready;
  assign w_ar_hs = s_axi_arvalid & r_arready;
  assign w_r_hs  = r_rvalid & s_axi_rready;

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = r_rlast;

  // lock/cache/prot carry no meaning for a local buffer; wlast is not used for beat counting
  assign w_unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

  // Write FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state: beat count alone closes the burst
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_BURST;
      W_BURST: if (w_w_hs && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs decoded from the next state (registered below)
  always_comb begin
    w_awready_nxt = (w_wstate_nxt == W_IDLE);
    w_wready_nxt  = (w_wstate_nxt == W_BURST);
    w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
  end

  // Registered write handshakes so every ready/valid reads 0 while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
    end
  end

  // Write burst bookkeeping: capture AW fields, step address per accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_bid    <= '0;
    end else if (w_aw_hs) begin
      r_waddr  <= s_axi_awaddr;
      r_wlen   <= s_axi_awlen;
      r_wcnt   <= '0;
      r_wsize  <= s_axi_awsize;
      r_wburst <= s_axi_awburst;
      r_bid    <= s_axi_awid;
    end else if (w_w_hs) begin
      r_waddr  <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
      r_wcnt   <= r_wcnt + 8'd1;
    end
  end

  // Byte-enabled buffer write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_waddr[ADDR_WIDTH-1:LSB]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= R_IDLE;
    else      r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state; R_PREP is the extra first-beat stage of the pipelined variant
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = PIPELINE_OUTPUT ? R_PREP : R_BURST;
      R_PREP:  w_rstate_nxt = R_BURST;
      R_BURST: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs decoded from the next state (registered below)
  always_comb begin
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
    w_rvalid_nxt  = (w_rstate_nxt == R_BURST);
  end

  // Registered read handshakes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
    end
  end

  // Select which beat to fetch into the R output register this cycle
  always_comb begin
    w_fetch = 1'b0;
    w_faddr = r_raddr;
    w_flen  = r_rlen;
    w_fbeat = '0;
    case (r_rstate)
      R_IDLE: begin
        w_fetch = w_ar_hs && !PIPELINE_OUTPUT;
        w_faddr = s_axi_araddr;
        w_flen  = s_axi_arlen;
      end
      R_PREP: w_fetch = 1'b1;
      R_BURST: begin
        w_fetch = w_r_hs && !r_rlast;
        w_faddr = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
        w_fbeat = r_rbeat + 8'd1;
      end
      default: w_fetch = 1'b0;
    endcase
  end

  // Read data path: output only changes on a fetch, so stalls hold rdata/rid/rlast
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_raddr  <= s_axi_araddr;
        r_rlen   <= s_axi_arlen;
        r_rsize  <= s_axi_arsize;
        r_rburst <= s_axi_arburst;
        r_rid    <= s_axi_arid;
      end
      if (w_fetch) begin
        r_rdata <= r_mem[w_faddr[ADDR_WIDTH-1:LSB]];
        r_raddr <= w_faddr;
        r_rbeat <= w_fbeat;
        r_rlast <= (w_fbeat == w_flen);
      end else if (w_r_hs && r_rlast) begin
        r_rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_top_32x32_ws.sv
// Randomized bench for axi_top_32x32_ws with a word-array reference model
// covering the low 1 KiB of the buffer; a second instance covers the
// pipelined R channel.
module tb_axi_top_32x32_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  awid, arid, bid, rid;
  logic [19:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  logic [7:0]  p_arid, p_rid, p_bid;
  logic [19:0] p_araddr;
  logic [7:0]  p_arlen;
  logic [2:0]  p_arsize;
  logic [1:0]  p_arburst, p_rresp, p_bresp;
  logic        p_arvalid, p_arready, p_rvalid, p_rready, p_rlast;
  logic        p_awready, p_wready, p_bvalid;
  logic [31:0] p_rdata;

  axi_top_32x32_ws #(.PIPELINE_OUTPUT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  axi_top_32x32_ws #(.PIPELINE_OUTPUT(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .s_axi_awid(8'h0), .s_axi_awaddr(20'h0), .s_axi_awlen(8'h0), .s_axi_awsize(3'h0),
    .s_axi_awburst(2'h0), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awvalid(1'b0), .s_axi_awready(p_awready),
    .s_axi_wdata(32'h0), .s_axi_wstrb(4'h0), .s_axi_wlast(1'b0),
    .s_axi_wvalid(1'b0), .s_axi_wready(p_wready),
    .s_axi_bid(p_bid), .s_axi_bresp(p_bresp), .s_axi_bvalid(p_bvalid), .s_axi_bready(1'b0),
    .s_axi_arid(p_arid), .s_axi_araddr(p_araddr), .s_axi_arlen(p_arlen), .s_axi_arsize(p_arsize),
    .s_axi_arburst(p_arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arvalid(p_arvalid), .s_axi_arready(p_arready),
    .s_axi_rid(p_rid), .s_axi_rdata(p_rdata), .s_axi_rresp(p_rresp), .s_axi_rlast(p_rlast),
    .s_axi_rvalid(p_rvalid), .s_axi_rready(p_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: 256 words covering byte addresses 0x000-0x3FF
  logic [31:0] model_mem [256];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];
  logic [31:0] rd_q [$];

  // Byte address of beat i, straight from the burst rules
  function automatic int unsigned beat_addr(input int unsigned start, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned i);
    int unsigned bytes, wsz, base;
    bytes = 1 << size;
    wsz   = (len + 1) * bytes;
    case (burst)
      0:       return start;
      2: begin
        base = (start / wsz) * wsz;
        return base + ((start - base) + i * bytes) % wsz;
      end
      default: return start + i * bytes;
    endcase
  endfunction

  task automatic axi_write(input logic [7:0] id, input logic [19:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit gaps);
    int n;
    int unsigned a;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check_eq("awready_wait", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      check_eq("wready_wait", wready, 1'b1);
      a = beat_addr(addr, len, size, burst, i);
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) model_mem[(a >> 2) & 255][b*8 +: 8] = wdata[b*8 +: 8];
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check_eq("bvalid_wait", bvalid, 1'b1);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("bvalid_hold", bvalid, 1'b1);
      end
    end
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_clear", bvalid, 1'b0);
  endtask

  // mode 0: rready always high, 1: rready toggles 0/1, 2: random stalls
  task automatic axi_read(input logic [7:0] id, input logic [19:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int n, lat, stall;
    logic [31:0] held;
    int unsigned a;
    rd_q.delete();
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check_eq("arready_wait", arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    check_eq("r_latency", lat, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      check_eq("rvalid_wait", rvalid, 1'b1);
      stall = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      held = rdata;
      repeat (stall) begin
        rready = 1'b0;
        @(negedge clk);
        check_eq("rdata_stall", rdata, held);
        check_eq("rvalid_stall", rvalid, 1'b1);
      end
      a = beat_addr(addr, len, size, burst, i);
      check_eq("rdata", rdata, model_mem[(a >> 2) & 255]);
      check_eq("rid", rid, id);
      check_eq("rresp", rresp, 2'b00);
      check_eq("rlast", rlast, (i == int'(len)));
      rd_q.push_back(rdata);
      rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    check_eq("rvalid_clear", rvalid, 1'b0);
  endtask

  task automatic load_beats(input int cnt, input bit rnd);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < cnt; i++) begin
      wq_data.push_back(rnd ? $urandom : 32'(i + 1));
      wq_strb.push_back(4'hF);
    end
  endtask

  initial begin
    int lat, n;
    int unsigned len_r, size_r, burst_r, start_r;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    p_arid = '0; p_araddr = '0; p_arlen = '0; p_arsize = '0; p_arburst = '0;
    p_arvalid = 1'b0; p_rready = 1'b0;

    #2 rst = 1'b0;
    #10;
    check_eq("rst_awready", awready, 1'b0);
    check_eq("rst_wready", wready, 1'b0);
    check_eq("rst_bvalid", bvalid, 1'b0);
    check_eq("rst_arready", arready, 1'b0);
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_rid", rid, 8'h0);
    check_eq("rst_bid", bid, 8'h0);
    check_eq("rst_rlast", rlast, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_eq("idle_awready", awready, 1'b1);
    check_eq("idle_arready", arready, 1'b1);
    check_eq("p_idle_awready", p_awready, 1'b1);
    check_eq("p_idle_wready", p_wready, 1'b0);
    check_eq("p_idle_bvalid", p_bvalid, 1'b0);
    check_eq("p_idle_bid", {p_bid, p_bresp}, 10'h0);

    // Fill the modelled region with one long INCR burst
    load_beats(256, 1'b1);
    axi_write(8'h0, 20'h0, 8'd255, 3'd2, 2'b01, 1'b0);

    // Single beat write and readback
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    axi_write(8'h01, 20'h00010, 8'd0, 3'd2, 2'b01, 1'b0);
    axi_read(8'h02, 20'h00010, 8'd0, 3'd2, 2'b01, 0);
    check_eq("single_lit", rd_q[0], 32'hDEADBEEF);

    // Partial strobe write
    wq_data = '{32'h12345678}; wq_strb = '{4'b0011};
    axi_write(8'h03, 20'h00010, 8'd0, 3'd2, 2'b01, 1'b0);
    axi_read(8'h04, 20'h00010, 8'd0, 3'd2, 2'b01, 0);
    check_eq("strb_lit", rd_q[0], 32'hDEAD5678);

    // INCR burst 1..4, read back plain and with rready toggling
    load_beats(4, 1'b0);
    axi_write(8'h05, 20'h00100, 8'd3, 3'd2, 2'b01, 1'b1);
    axi_read(8'h06, 20'h00100, 8'd3, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) check_eq("incr_lit", rd_q[i], 32'(i + 1));
    axi_read(8'h07, 20'h00100, 8'd3, 3'd2, 2'b01, 1);
    for (int i = 0; i < 4; i++) check_eq("toggle_lit", rd_q[i], 32'(i + 1));

    // WRAP from 0x108 lands on 0x108,0x10C,0x100,0x104
    wq_data = '{32'hA, 32'hB, 32'hC, 32'hD}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(8'h08, 20'h00108, 8'd3, 3'd2, 2'b10, 1'b0);
    axi_read(8'h09, 20'h00100, 8'd3, 3'd2, 2'b01, 0);
    check_eq("wrap_lit0", rd_q[0], 32'hC);
    check_eq("wrap_lit1", rd_q[1], 32'hD);
    check_eq("wrap_lit2", rd_q[2], 32'hA);
    check_eq("wrap_lit3", rd_q[3], 32'hB);
    axi_read(8'h0A, 20'h00108, 8'd3, 3'd2, 2'b10, 2);

    // FIXED burst: all beats hit one word, last one wins
    wq_data = '{32'h111, 32'h222, 32'h333}; wq_strb = '{4'hF, 4'hF, 4'hF};
    axi_write(8'h0B, 20'h00200, 8'd2, 3'd2, 2'b00, 1'b0);
    axi_read(8'h0C, 20'h00200, 8'd2, 3'd2, 2'b00, 0);
    for (int i = 0; i < 3; i++) check_eq("fixed_lit", rd_q[i], 32'h333);
    axi_read(8'h0D, 20'h00204, 8'd0, 3'd2, 2'b01, 0);

    // Reset in the middle of a write burst: first beat lands, the rest is dropped
    @(negedge clk);
    awid = 8'h5A; awaddr = 20'h00300; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check_eq("mid_awready", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    check_eq("mid_wready", wready, 1'b1);
    model_mem[8'hC0] = 32'hCAFE0001;
    @(negedge clk);
    wdata = 32'hCAFE0002;
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_awready", awready, 1'b0);
    check_eq("mid_rst_wready", wready, 1'b0);
    check_eq("mid_rst_bvalid", bvalid, 1'b0);
    check_eq("mid_rst_arready", arready, 1'b0);
    check_eq("mid_rst_rvalid", rvalid, 1'b0);
    check_eq("mid_rst_bid", bid, 8'h0);
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    axi_read(8'h0E, 20'h00300, 8'd1, 3'd2, 2'b01, 0);
    wq_data = '{32'h600DF00D}; wq_strb = '{4'hF};
    axi_write(8'h0F, 20'h00304, 8'd0, 3'd2, 2'b01, 1'b0);
    axi_read(8'h10, 20'h00304, 8'd0, 3'd2, 2'b01, 0);
    check_eq("post_rst_lit", rd_q[0], 32'h600DF00D);

    // Pipelined R channel: rvalid two cycles after the AR handshake
    @(negedge clk);
    p_arid = 8'h77; p_araddr = 20'h00040; p_arlen = 8'd1; p_arsize = 3'd2; p_arburst = 2'b01;
    p_arvalid = 1'b1;
    n = 0;
    while (!p_arready && n < 50) begin @(negedge clk); n++; end
    check_eq("p_arready_wait", p_arready, 1'b1);
    @(negedge clk);
    p_arvalid = 1'b0;
    lat = 1;
    while (!p_rvalid && lat < 50) begin @(negedge clk); lat++; end
    check_eq("p_latency", lat, 2);
    check_eq("p_rid", p_rid, 8'h77);
    check_eq("p_rresp", p_rresp, 2'b00);
    check_eq("p_rlast0", p_rlast, 1'b0);
    p_rready = 1'b1;
    @(negedge clk);
    check_eq("p_rvalid1", p_rvalid, 1'b1);
    check_eq("p_rlast1", p_rlast, 1'b1);
    @(negedge clk);
    p_rready = 1'b0;
    check_eq("p_rvalid_clear", p_rvalid, 1'b0);
    check_eq("p_rdata_seen", ^p_rdata !== 1'bx, 1'b1);

    // Random mix of bursts inside the modelled region
    for (int t = 0; t < 40; t++) begin
      burst_r = $urandom_range(0, 3);
      size_r  = $urandom_range(0, 2);
      if (burst_r == 2) len_r = (2 << $urandom_range(0, 3)) - 1;
      else              len_r = $urandom_range(0, 15);
      start_r = $urandom_range(0, 240) * 4;
      if ($urandom_range(0, 1) == 1) begin
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i <= int'(len_r); i++) begin
          wq_data.push_back($urandom);
          wq_strb.push_back(4'($urandom_range(0, 15)));
        end
        axi_write(8'($urandom), 20'(start_r), 8'(len_r), 3'(size_r), 2'(burst_r), 1'b1);
      end else begin
        axi_read(8'($urandom), 20'(start_r), 8'(len_r), 3'(size_r), 2'(burst_r),
                 int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
